mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares port A of Memory_Management (32K x 16, synchronous, 15-bit address) between two requesters: M0 (processor load/store unit) and M1 (loader/DMA).
- Drives the memory's enA/wenA/AddressA/WriteDataA and routes ReadDataA back to the owning requester.
- Pipelined: accepts at most one access per cycle, full throughput, fixed read latency.

Parameters:
- AW, 15, address width (matches the memory).
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  AW  M0 word address.
- m0_wdata  in  DW  M0 write data.
- m0_gnt  out  1  M0 request accepted this cycle (combinational).
- m0_rvalid  out  1  M0 read data valid.
- m0_rdata  out  DW  M0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as M0, for M1.
- m1_lock  in  1  M1 holds ownership while asserted (bursts).
- mem_en  out  1  to enA.
- mem_wen  out  1  to wenA.
- mem_addr  out  AW  to AddressA.
- mem_wdata  out  DW  to WriteDataA.
- mem_rdata  in  DW  from ReadDataA (valid the cycle after the memory samples a read).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, m0_rvalid=m1_rvalid=0, RR pointer=M0-preferred, lock state cleared. Gnts are low while rst_n=0.
- Handshake: a transfer occurs at the rising edge where mX_req && mX_gnt. The requester holds req/we/addr/wdata stable until that edge and may change them afterwards.
- Grant logic (combinational):
  - At most one gnt is high per cycle.
  - A gnt is never high without its req.
- Arbitration: round-robin on a 1-bit pointer.
  - If only one requester is asserting, it wins.
  - If both assert, the pointer decides. The pointer flips to the other requester after each transfer.
- Lock:
  - If M1 has the last grant and m1_lock=1, M1 keeps priority over M0 on every cycle.
  - The lock releases in the first cycle with m1_lock=0.
  - Lock is ignored while M0 holds the pointer.
- Issue stage (registered):
  - On transfer at edge N, the cycle N+1 outputs are mem_en=1, mem_wen=we, mem_addr=addr, mem_wdata=wdata.
  - With no transfer, the next cycle has mem_en=0 and mem_wen=0. Address and data hold their last value.
- Read return:
  - The memory samples at the end of cycle N+1, and mem_rdata is valid in cycle N+2.
  - A 2-stage owner/read tag pipeline asserts mX_rvalid in cycle N+2, for exactly one cycle per accepted read.
  - Writes produce no rvalid.
  - mX_rdata = mem_rdata continuously. It is meaningful only with rvalid.
- Throughput: back-to-back transfers every cycle. Reads from alternating owners return in issue order with no bubbles.
- Read-after-write to the same address on consecutive transfers: the read returns the newly written data. The memory write completes before the read sample.
- Address range: 0..2^AW-1, including 0x7FFF. No wrap or check logic.
- Reset mid-operation: in-flight read tags are discarded. No rvalid is asserted after reset for requests accepted before reset.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, M0 always wins when both request. The pointer and m1_lock are ignored; m1_lock becomes a no-op input.
- Undefined: round-robin plus lock, as in Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a read in flight -> mem_en=0 and both rvalid=0 immediately. No rvalid appears after release.
- Single requester write then read: M0 writes addr 0x0005 data 0x1234, then reads 0x0005 -> m0_rvalid pulses 2 cycles after the read gnt with m0_rdata=0x1234.
- Contention: M0 and M1 both hold reads every cycle (M0 addr 0x0010, M1 addr 0x0020) -> grants alternate M0,M1,M0,M1. Rvalids alternate with no gaps and carry the correct data.
- Lock burst: M1 gets the grant with m1_lock=1 for 4 reads while M0 requests continuously -> 4 consecutive M1 gnts, then M0 is granted the cycle after lock drops.
- Boundary sweep: write addr=data for 1..0x7FFE, then read back through both ports interleaved -> every rdata equals its address, with zero mismatches.
- ARB_FIXED_PRIO_EN build: both request continuously -> M0 granted every cycle and M1 is starved. M1 is granted the first cycle after M0 deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for memory port A: round-robin with M1 burst lock, registered issue
// stage and a 2-stage read-owner tag pipeline. Define ARB_FIXED_PRIO_EN for M0-first fixed priority.
module mem_port_arbiter #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_lock,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;

  logic          w_pref_m1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_xfer;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  logic          r_mem_en;
  logic          r_mem_wen;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_rd1_v;
  logic          r_rd2_v;
  owner_t        r_rd1_own;
  owner_t        r_rd2_own;

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused_lock;
  assign w_unused_lock = m1_lock;
  assign w_pref_m1     = 1'b0;
`else
  owner_t r_ptr;
  logic   r_lock;

  // Lock is armed only by an M1 transfer made with m1_lock high, and drops as soon as m1_lock falls.
  assign w_pref_m1 = (r_ptr == OWN_M1) || (r_lock && m1_lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= OWN_M0;
      r_lock <= 1'b0;
    end else if (w_xfer) begin
      r_ptr  <= w_gnt1 ? OWN_M0 : OWN_M1;
      r_lock <= w_gnt1 && m1_lock;
    end else if (!m1_lock) begin
      r_lock <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        w_gnt0 = !w_pref_m1;
        w_gnt1 = w_pref_m1;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_xfer  = w_gnt0 || w_gnt1;
  assign w_we    = w_gnt1 ? m1_we    : m0_we;
  assign w_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt1 ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd1_v     <= 1'b0;
      r_rd2_v     <= 1'b0;
      r_rd1_own   <= OWN_M0;
      r_rd2_own   <= OWN_M0;
    end else begin
      r_mem_en  <= w_xfer;
      r_mem_wen <= w_xfer && w_we;
      if (w_xfer) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
      end
      r_rd1_v   <= w_xfer && !w_we;
      r_rd1_own <= w_gnt1 ? OWN_M1 : OWN_M0;
      r_rd2_v   <= r_rd1_v;
      r_rd2_own <= r_rd1_own;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_en    = r_mem_en;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign m0_rvalid = r_rd2_v && (r_rd2_own == OWN_M0);
  assign m1_rvalid = r_rd2_v && (r_rd2_own == OWN_M1);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32Kx16 memory and an in-order read scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk, rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) mem_model[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic          own;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            total, bad, cyc;
  logic          g0, g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expg(input string tag, input logic e0, input logic e1);
    chk({tag, "_gnt0"}, 32'(g0), 32'(e0));
    chk({tag, "_gnt1"}, 32'(g1), 32'(e1));
  endtask

  task automatic set0(input logic req, input logic we, input int addr, input int data);
    m0_req = req; m0_we = we; m0_addr = AW'(addr); m0_wdata = DW'(data);
  endtask

  task automatic set1(input logic req, input logic we, input int addr, input int data);
    m1_req = req; m1_we = we; m1_addr = AW'(addr); m1_wdata = DW'(data);
  endtask

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
  endtask

  // One clock: sample grants mid-cycle, book expectations, then check read returns after the edge.
  task automatic tick();
    logic          rv;
    logic [DW-1:0] rd;
    exp_t          e;
    @(negedge clk);
    g0 = m0_gnt;
    g1 = m1_gnt;
    chk("gnt_onehot", 32'(g0 & g1), 0);
    chk("gnt_without_req", 32'((g0 & ~m0_req) | (g1 & ~m1_req)), 0);
    if (g0) begin
      if (m0_we) shadow[m0_addr] = m0_wdata;
      else       sb.push_back('{1'b0, shadow[m0_addr], cyc + 2});
    end
    if (g1) begin
      if (m1_we) shadow[m1_addr] = m1_wdata;
      else       sb.push_back('{1'b1, shadow[m1_addr], cyc + 2});
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("rvalid_both", 32'(m0_rvalid & m1_rvalid), 0);
    for (int p = 0; p < 2; p++) begin
      rv = (p == 0) ? m0_rvalid : m1_rvalid;
      rd = (p == 0) ? m0_rdata  : m1_rdata;
      if (rv) begin
        chk("rvalid_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rvalid_owner", 32'(e.own), 32'(p));
          chk("rdata", 32'(rd), 32'(e.data));
          chk("rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
    chk("rvalid_missing", 32'(sb.size() != 0 && sb[0].due <= cyc), 0);
    if (sb.size() != 0 && sb[0].due <= cyc) void'(sb.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, n;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    idle();
    set0(1'b1, 1'b0, 0, 0);
    set1(1'b1, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en",    32'(mem_en), 0);
    chk("rst_mem_wen",   32'(mem_wen), 0);
    chk("rst_mem_addr",  32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_m0_gnt",    32'(m0_gnt), 0);
    chk("rst_m1_gnt",    32'(m1_gnt), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester: write then read back with latency and hold checks.
    set0(1'b1, 1'b1, 'h0005, 'h1234);
    tick(); expg("wr", 1'b1, 1'b0);
    chk("issue_wr_en",    32'(mem_en), 1);
    chk("issue_wr_wen",   32'(mem_wen), 1);
    chk("issue_wr_addr",  32'(mem_addr), 'h0005);
    chk("issue_wr_wdata", 32'(mem_wdata), 'h1234);
    set0(1'b1, 1'b0, 'h0005, 'h5555);
    tick(); expg("rd", 1'b1, 1'b0);
    chk("issue_rd_en",   32'(mem_en), 1);
    chk("issue_rd_wen",  32'(mem_wen), 0);
    chk("rd_not_early",  32'(m0_rvalid), 0);
    idle();
    tick();
    chk("idle_en",        32'(mem_en), 0);
    chk("idle_wen",       32'(mem_wen), 0);
    chk("hold_addr",      32'(mem_addr), 'h0005);
    chk("hold_wdata",     32'(mem_wdata), 'h5555);
    chk("rd_pulse",       32'(m0_rvalid), 1);
    chk("rd_data",        32'(m0_rdata), 'h1234);
    chk("rd_other_quiet", 32'(m1_rvalid), 0);
    tick();
    chk("rd_one_cycle",   32'(m0_rvalid), 0);

    // Contention: both hold reads every cycle.
    set0(1'b1, 1'b1, 'h0010, 'hA5A5); tick(); m0_req = 1'b0;
    set1(1'b1, 1'b1, 'h0020, 'h5A5A); tick(); m1_req = 1'b0;
    set0(1'b1, 1'b0, 'h0010, 0);
    set1(1'b1, 1'b0, 'h0020, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      expg("contend", 1'b1, 1'b0);
`else
      expg("contend", (i % 2) == 0, (i % 2) == 1);
`endif
    end
    idle();
    repeat (3) tick();
    chk("contend_drained", 32'(sb.size()), 0);

    // Lock burst: M1 takes the pointer, then keeps four grants while M0 keeps requesting.
    set0(1'b1, 1'b0, 'h0010, 0);
    tick(); expg("lock_pre", 1'b1, 1'b0);
    set1(1'b1, 1'b0, 'h0020, 0);
    m1_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      expg("lock_burst", 1'b1, 1'b0);
`else
      expg("lock_burst", 1'b0, 1'b1);
`endif
    end
    m1_lock = 1'b0;
    tick(); expg("lock_release", 1'b1, 1'b0);
    tick();
`ifdef ARB_FIXED_PRIO_EN
    expg("lock_after", 1'b1, 1'b0);
`else
    expg("lock_after", 1'b0, 1'b1);
`endif
    idle();
    repeat (3) tick();
    chk("lock_drained", 32'(sb.size()), 0);

    // Address extremes and read-after-write on consecutive transfers.
    set1(1'b1, 1'b1, 'h7FFF, 'hBEEF); tick(); expg("top_wr", 1'b0, 1'b1); m1_req = 1'b0;
    chk("issue_top_addr", 32'(mem_addr), 'h7FFF);
    set0(1'b1, 1'b0, 'h7FFF, 0);      tick(); expg("top_rd", 1'b1, 1'b0); m0_req = 1'b0;
    set0(1'b1, 1'b1, 'h0000, 'h0F0F); tick(); expg("zero_wr", 1'b1, 1'b0); m0_req = 1'b0;
    set1(1'b1, 1'b0, 'h0000, 0);      tick(); expg("zero_rd", 1'b0, 1'b1); m1_req = 1'b0;
    repeat (3) tick();
    chk("edge_drained", 32'(sb.size()), 0);

    // Sweep: M0 owns odd, M1 even addresses; write addr=data, then read everything back.
    a0 = 1; a1 = 2; n = 0;
    while ((a0 <= 'h7FFD || a1 <= 'h7FFE) && n < 40000) begin
      set0(a0 <= 'h7FFD, 1'b1, a0, a0);
      set1(a1 <= 'h7FFE, 1'b1, a1, a1);
      tick(); n++;
      if (g0) a0 += 2;
      if (g1) a1 += 2;
    end
    chk("sweep_wr_in_budget", 32'(n < 40000), 1);
    a0 = 1; a1 = 2; n = 0;
    while ((a0 <= 'h7FFD || a1 <= 'h7FFE) && n < 40000) begin
      set0(a0 <= 'h7FFD, 1'b0, a0, 0);
      set1(a1 <= 'h7FFE, 1'b0, a1, 0);
      tick(); n++;
      if (g0) a0 += 2;
      if (g1) a1 += 2;
    end
    chk("sweep_rd_in_budget", 32'(n < 40000), 1);
    idle();
    repeat (3) tick();
    chk("sweep_drained", 32'(sb.size()), 0);

    // Reset with a read in flight and another request pending.
    set0(1'b1, 1'b0, 'h0005, 0);
    tick(); expg("pre_rst", 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en",    32'(mem_en), 0);
    chk("midrst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("midrst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("midrst_m0_gnt",    32'(m0_gnt), 0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold_rvalid", 32'(m0_rvalid | m1_rvalid), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_rvalid", 32'(m0_rvalid | m1_rvalid), 0);
    end
    set0(1'b1, 1'b0, 'h0010, 0);
    set1(1'b1, 1'b0, 'h0020, 0);
    tick(); expg("postrst_ptr", 1'b1, 1'b0);
    idle();
    repeat (3) tick();

`ifdef ARB_FIXED_PRIO_EN
    set0(1'b1, 1'b0, 'h0010, 0);
    set1(1'b1, 1'b0, 'h0020, 0);
    m1_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); expg("fixed_starve", 1'b1, 1'b0);
    end
    m0_req = 1'b0;
    tick(); expg("fixed_m1_after", 1'b0, 1'b1);
    idle();
    repeat (3) tick();
`endif

    chk("final_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
